// File: rtl/iir_mc_pkg.sv
// Shared types and helpers for the multi-channel IIR filter.
// Coefficient storage is sized for the largest supported configuration; modules slice what they use.
package iir_mc_pkg;

    localparam int MAX_TAPS      = 16;
    localparam int MAX_DATA_SIZE = 64;
    localparam int ACC_MAX_W     = 2 * MAX_DATA_SIZE;

    typedef logic [MAX_DATA_SIZE-1:0] coeff_arr_t [MAX_TAPS];

    typedef enum logic [1:0] {
        S_READ  = 2'd0,
        S_MAC   = 2'd1,
        S_WRITE = 2'd2
    } state_t;

    function automatic int idx_w(input int n);
        return (n > 1) ? $clog2(n) : 1;
    endfunction

    // Signed divide by 2^frac_bits rounding toward zero: bias negatives up before the arithmetic shift.
    function automatic logic signed [ACC_MAX_W-1:0] dequantize(input logic signed [ACC_MAX_W-1:0] acc,
                                                               input int frac_bits);
        logic signed [ACC_MAX_W-1:0] bias;
        bias = acc[ACC_MAX_W-1] ? ((ACC_MAX_W'(1) << frac_bits) - ACC_MAX_W'(1)) : '0;
        return (acc + bias) >>> frac_bits;
    endfunction

endpackage

// File: rtl/iir_mc_if.sv
// Stream interface of the IIR filter: input FIFO write side, output FIFO read side, busy flag.
// master drives samples and read enables; slave is the filter.
interface iir_mc_if #(
    parameter int DATA_SIZE = 32,
    parameter int CHAN_W    = 1
);
    logic [DATA_SIZE-1:0] x_in_din;
    logic                 x_in_wr_en;
    logic                 x_in_full;
    logic [DATA_SIZE-1:0] y_out_dout;
    logic                 y_out_rd_en;
    logic                 y_out_empty;
    logic [CHAN_W-1:0]    y_out_chan;
    logic                 busy;

    modport master (output x_in_din, x_in_wr_en, y_out_rd_en,
                    input  x_in_full, y_out_dout, y_out_empty, y_out_chan, busy);
    modport slave  (input  x_in_din, x_in_wr_en, y_out_rd_en,
                    output x_in_full, y_out_dout, y_out_empty, y_out_chan, busy);
endinterface

// File: rtl/fifo.sv
// Generic show-ahead FIFO: dout is the head entry whenever empty is low, zero otherwise.
// One-cycle write-to-visible latency; writes when full and reads when empty are dropped.
module fifo #(
    parameter int WIDTH = 8,
    parameter int DEPTH = 16
) (
    input  logic             clock,
    input  logic             reset,
    input  logic             wr_en,
    input  logic [WIDTH-1:0] din,
    output logic             full,
    input  logic             rd_en,
    output logic [WIDTH-1:0] dout,
    output logic             empty
);
    localparam int AW = (DEPTH > 1) ? $clog2(DEPTH) : 1;
    localparam int CW = $clog2(DEPTH + 1);

    logic [WIDTH-1:0] mem [DEPTH];
    logic [AW-1:0]    wr_ptr, rd_ptr;
    logic [CW-1:0]    count;
    logic             do_wr, do_rd;

    assign full  = (count == CW'(DEPTH));
    assign empty = (count == '0);
    assign do_wr = wr_en && !full;
    assign do_rd = rd_en && !empty;
    assign dout  = empty ? '0 : mem[rd_ptr];

    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            count  <= '0;
        end else begin
            if (do_wr) wr_ptr <= (wr_ptr == AW'(DEPTH - 1)) ? '0 : wr_ptr + 1'b1;
            if (do_rd) rd_ptr <= (rd_ptr == AW'(DEPTH - 1)) ? '0 : rd_ptr + 1'b1;
            case ({do_wr, do_rd})
                2'b10:   count <= count + 1'b1;
                2'b01:   count <= count - 1'b1;
                default: ;
            endcase
        end
    end

    always_ff @(posedge clock) begin
        if (do_wr) mem[wr_ptr] <= din;
    end

endmodule

// File: rtl/iir_mc_core.sv
// Time-shared IIR engine: per-channel histories, one MAC per cycle, TAPS+2 cycles per sample.
// Waits in S_READ for input; holds in S_WRITE without committing while the output FIFO is full.
module iir_mc_core
    import iir_mc_pkg::*;
#(
    parameter int         CHANNELS   = 2,
    parameter int         TAPS       = 2,
    parameter int         DATA_SIZE  = 32,
    parameter int         BITS       = 10,
    parameter int         DECIMATION = 1,
    parameter coeff_arr_t X_COEFFS   = '{0: 64'h0000_00B2, 1: 64'h0000_00B2, default: '0},
    parameter coeff_arr_t Y_COEFFS   = '{1: 64'hFFFF_FFFF_FFFF_FD66, default: '0},
    localparam int        CHAN_W     = idx_w(CHANNELS)
) (
    input  logic                        clock,
    input  logic                        reset,
    input  logic [DATA_SIZE-1:0]        in_dat,
    input  logic                        in_empty,
    output logic                        in_pop,
    input  logic                        out_full,
    output logic                        out_push,
    output logic [CHAN_W+DATA_SIZE-1:0] out_dat,
    output logic                        busy
);
    localparam int TAP_W = idx_w(TAPS);
    localparam int DEC_W = idx_w(DECIMATION);
    localparam int ACC_W = 2 * DATA_SIZE;

    state_t                      state_q, state_d;
    logic signed [DATA_SIZE-1:0] x_hist [CHANNELS][TAPS];
    logic signed [DATA_SIZE-1:0] y_hist [CHANNELS][TAPS];
    logic signed [ACC_W-1:0]     acc_q, prod;
    logic [TAP_W-1:0]            tap_q;
    logic [CHAN_W-1:0]           chan_q;
    logic [DEC_W-1:0]            dec_q;
    logic signed [DATA_SIZE-1:0] coef_x, coef_y, samp_x, samp_y, result;
    logic                        commit;

    always_ff @(posedge clock or negedge reset) begin
        if (!reset) state_q <= S_READ;
        else        state_q <= state_d;
    end

    always_comb begin
        state_d  = state_q;
        in_pop   = 1'b0;
        commit   = 1'b0;
        out_push = 1'b0;
        unique case (state_q)
            S_READ: begin
                if (!in_empty) begin
                    in_pop  = 1'b1;
                    state_d = S_MAC;
                end
            end
            S_MAC: begin
                if (tap_q == TAP_W'(TAPS - 1)) state_d = S_WRITE;
            end
            S_WRITE: begin
                if (!out_full) begin
                    commit   = 1'b1;
                    out_push = (dec_q == DEC_W'(DECIMATION - 1));
                    state_d  = S_READ;
                end
            end
            default: state_d = S_READ;
        endcase
    end

    // Tap operand select; the feedback path sees the y history one slot late, so tap 0 has no y term.
    always_comb begin
        coef_x = '0;
        coef_y = '0;
        samp_x = '0;
        samp_y = '0;
        for (int i = 0; i < TAPS; i++) begin
            if (tap_q == TAP_W'(i)) begin
                coef_x = X_COEFFS[i][DATA_SIZE-1:0];
                coef_y = Y_COEFFS[i][DATA_SIZE-1:0];
                samp_x = x_hist[chan_q][i];
                if (i > 0) samp_y = y_hist[chan_q][(i > 0) ? i - 1 : 0];
            end
        end
    end

    assign prod    = ACC_W'(coef_x) * ACC_W'(samp_x) + ACC_W'(coef_y) * ACC_W'(samp_y);
    assign result  = DATA_SIZE'(dequantize(ACC_MAX_W'(acc_q), BITS));
    assign out_dat = {chan_q, result};
    assign busy    = (state_q != S_READ);

    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            for (int c = 0; c < CHANNELS; c++) begin
                for (int i = 0; i < TAPS; i++) begin
                    x_hist[c][i] <= '0;
                    y_hist[c][i] <= '0;
                end
            end
            acc_q  <= '0;
            tap_q  <= '0;
            chan_q <= '0;
            dec_q  <= '0;
        end else begin
            if (in_pop) begin
                x_hist[chan_q][0] <= in_dat;
                for (int i = 1; i < TAPS; i++) x_hist[chan_q][i] <= x_hist[chan_q][i-1];
                acc_q <= '0;
                tap_q <= '0;
            end
            if (state_q == S_MAC) begin
                acc_q <= acc_q + prod;
                tap_q <= tap_q + 1'b1;
            end
            if (commit) begin
                y_hist[chan_q][0] <= result;
                for (int i = 1; i < TAPS; i++) y_hist[chan_q][i] <= y_hist[chan_q][i-1];
                if (chan_q == CHAN_W'(CHANNELS - 1)) begin
                    chan_q <= '0;
                    dec_q  <= (dec_q == DEC_W'(DECIMATION - 1)) ? '0 : dec_q + 1'b1;
                end else begin
                    chan_q <= chan_q + 1'b1;
                end
            end
        end
    end

endmodule

// File: rtl/iir_mc_top.sv
// Multi-channel IIR filter between an input sample FIFO and a tagged output FIFO.
// Latency TAPS+2 cycles from pop to output write; input FIFO fills while the output FIFO is full.
module iir_mc_top
    import iir_mc_pkg::*;
#(
    parameter int         CHANNELS   = 2,
    parameter int         TAPS       = 2,
    parameter int         DATA_SIZE  = 32,
    parameter int         BITS       = 10,
    parameter int         DECIMATION = 1,
    parameter int         FIFO_DEPTH = 16,
    parameter coeff_arr_t X_COEFFS   = '{0: 64'h0000_00B2, 1: 64'h0000_00B2, default: '0},
    parameter coeff_arr_t Y_COEFFS   = '{1: 64'hFFFF_FFFF_FFFF_FD66, default: '0}
) (
    input  logic     clock,
    input  logic     reset,
    iir_mc_if.slave  bus
);
    localparam int CHAN_W = idx_w(CHANNELS);

    logic [DATA_SIZE-1:0]        in_dat;
    logic                        in_empty, in_pop;
    logic                        out_full, out_push;
    logic [CHAN_W+DATA_SIZE-1:0] out_dat, out_q;

    fifo #(.WIDTH(DATA_SIZE), .DEPTH(FIFO_DEPTH)) u_in_fifo (
        .clock (clock),
        .reset (reset),
        .wr_en (bus.x_in_wr_en),
        .din   (bus.x_in_din),
        .full  (bus.x_in_full),
        .rd_en (in_pop),
        .dout  (in_dat),
        .empty (in_empty)
    );

    iir_mc_core #(
        .CHANNELS   (CHANNELS),
        .TAPS       (TAPS),
        .DATA_SIZE  (DATA_SIZE),
        .BITS       (BITS),
        .DECIMATION (DECIMATION),
        .X_COEFFS   (X_COEFFS),
        .Y_COEFFS   (Y_COEFFS)
    ) u_core (
        .clock    (clock),
        .reset    (reset),
        .in_dat   (in_dat),
        .in_empty (in_empty),
        .in_pop   (in_pop),
        .out_full (out_full),
        .out_push (out_push),
        .out_dat  (out_dat),
        .busy     (bus.busy)
    );

    fifo #(.WIDTH(CHAN_W + DATA_SIZE), .DEPTH(FIFO_DEPTH)) u_out_fifo (
        .clock (clock),
        .reset (reset),
        .wr_en (out_push),
        .din   (out_dat),
        .full  (out_full),
        .rd_en (bus.y_out_rd_en),
        .dout  (out_q),
        .empty (bus.y_out_empty)
    );

    assign bus.y_out_chan = out_q[CHAN_W+DATA_SIZE-1:DATA_SIZE];
    assign bus.y_out_dout = out_q[DATA_SIZE-1:0];

endmodule

// File: tb/tb_iir_mc_top.sv
// Bench for iir_mc_top: three configurations (1 channel, 2 channels, 1 channel decimate-by-4).
module tb_iir_mc_top;
    localparam int DS = 32;

    logic clock = 1'b0;
    logic reset = 1'b1;
    always #5 clock = ~clock;

    iir_mc_if #(.DATA_SIZE(DS), .CHAN_W(1)) bus_c1 ();
    iir_mc_if #(.DATA_SIZE(DS), .CHAN_W(1)) bus_c2 ();
    iir_mc_if #(.DATA_SIZE(DS), .CHAN_W(1)) bus_d4 ();

    iir_mc_top #(.CHANNELS(1))                  u_c1 (.clock(clock), .reset(reset), .bus(bus_c1));
    iir_mc_top #(.CHANNELS(2))                  u_c2 (.clock(clock), .reset(reset), .bus(bus_c2));
    iir_mc_top #(.CHANNELS(1), .DECIMATION(4))  u_d4 (.clock(clock), .reset(reset), .bus(bus_d4));

    typedef struct {
        int dut;       // 0 = single channel, 1 = two channels
        int rst;       // pulse reset before applying
        int din;
        int exp_dat;
        int exp_chan;
    } vec_t;

    vec_t   vecs [12];
    int     d4_in [8];
    longint d4_exp [8];
    longint bp_exp [40];
    longint mx [2];
    longint my [2];
    int     tests_run = 0;
    int     tests_failed = 0;

    task automatic check(input string name, input logic signed [63:0] act, input logic signed [63:0] exp);
        tests_run++;
        if (act !== exp) begin
            tests_failed++;
            $display("FAIL %s: got %0d, expected %0d", name, act, exp);
        end
    endtask

    // Reference filter for the default coefficients: y = (178*x[n] + 178*x[n-1] - 666*y[n-1]) / 1024.
    function automatic void model_clear();
        for (int c = 0; c < 2; c++) begin
            mx[c] = 0;
            my[c] = 0;
        end
    endfunction

    function automatic longint model_step(input int ch, input longint x);
        longint acc;
        longint q;
        acc = 178 * x + 178 * mx[ch] - 666 * my[ch];
        q   = acc / 1024;
        mx[ch] = x;
        my[ch] = longint'(int'(q));
        return my[ch];
    endfunction

    function automatic int bp_val(input int i);
        return (((i * 73) % 512) - 256) * 8;
    endfunction

    function automatic logic full_of(input int d);
        case (d)
            0:       return bus_c1.x_in_full;
            1:       return bus_c2.x_in_full;
            default: return bus_d4.x_in_full;
        endcase
    endfunction

    function automatic logic empty_of(input int d);
        case (d)
            0:       return bus_c1.y_out_empty;
            1:       return bus_c2.y_out_empty;
            default: return bus_d4.y_out_empty;
        endcase
    endfunction

    task automatic idle_inputs();
        bus_c1.x_in_wr_en = 1'b0; bus_c1.y_out_rd_en = 1'b0;
        bus_c2.x_in_wr_en = 1'b0; bus_c2.y_out_rd_en = 1'b0;
        bus_d4.x_in_wr_en = 1'b0; bus_d4.y_out_rd_en = 1'b0;
    endtask

    task automatic do_reset();
        @(negedge clock);
        idle_inputs();
        reset = 1'b0;
        repeat (2) @(negedge clock);
        reset = 1'b1;
        @(negedge clock);
    endtask

    task automatic push(input int d, input int v);
        int n = 0;
        while (full_of(d) && n < 100) begin
            @(negedge clock);
            n++;
        end
        if (full_of(d)) begin
            tests_run++;
            tests_failed++;
            $display("FAIL push_timeout dut%0d: x_in_full still 1 after %0d cycles, required 0", d, n);
        end else begin
            case (d)
                0:       begin bus_c1.x_in_din = v; bus_c1.x_in_wr_en = 1'b1; end
                1:       begin bus_c2.x_in_din = v; bus_c2.x_in_wr_en = 1'b1; end
                default: begin bus_d4.x_in_din = v; bus_d4.x_in_wr_en = 1'b1; end
            endcase
            @(negedge clock);
            idle_inputs();
        end
    endtask

    task automatic pop(input int d, output bit ok, output logic signed [63:0] dat, output logic signed [63:0] ch);
        int n = 0;
        ok  = 1'b0;
        dat = '0;
        ch  = '0;
        while (empty_of(d) && n < 100) begin
            @(negedge clock);
            n++;
        end
        if (empty_of(d)) begin
            tests_run++;
            tests_failed++;
            $display("FAIL pop_timeout dut%0d: y_out_empty still 1 after %0d cycles, required 0", d, n);
        end else begin
            ok = 1'b1;
            case (d)
                0:       begin dat = $signed(bus_c1.y_out_dout); ch = bus_c1.y_out_chan; bus_c1.y_out_rd_en = 1'b1; end
                1:       begin dat = $signed(bus_c2.y_out_dout); ch = bus_c2.y_out_chan; bus_c2.y_out_rd_en = 1'b1; end
                default: begin dat = $signed(bus_d4.y_out_dout); ch = bus_d4.y_out_chan; bus_d4.y_out_rd_en = 1'b1; end
            endcase
            @(negedge clock);
            idle_inputs();
        end
    endtask

    initial begin
        #500000;
        $display("FAIL watchdog: simulation time limit reached before summary");
        $fatal(1, "watchdog");
    end

    initial begin
        bit                 ok;
        logic signed [63:0] dat, ch;
        int                 n_in, n_out, stall, guard;

        bus_c1.x_in_din = '0; bus_c2.x_in_din = '0; bus_d4.x_in_din = '0;
        idle_inputs();

        vecs[0]  = '{0, 1, 1024,  178, 0};
        vecs[1]  = '{0, 0, 0,     62,  0};
        vecs[2]  = '{0, 0, 0,    -40,  0};
        vecs[3]  = '{0, 0, 0,     26,  0};
        vecs[4]  = '{0, 1, -1024, -178, 0};
        vecs[5]  = '{0, 1, -1,    0,   0};
        vecs[6]  = '{1, 1, 1024,  178, 0};
        vecs[7]  = '{1, 0, 0,     0,   1};
        vecs[8]  = '{1, 0, 0,     62,  0};
        vecs[9]  = '{1, 0, 0,     0,   1};
        vecs[10] = '{1, 0, 0,    -40,  0};
        vecs[11] = '{1, 0, 512,   89,  1};
        d4_in = '{1024, 0, 0, 0, 512, -300, 0, 700};

        // Outputs while reset is held low.
        #2 reset = 1'b0;
        repeat (2) @(negedge clock);
        check("rst_c1_busy",  bus_c1.busy,        0);
        check("rst_c1_full",  bus_c1.x_in_full,   0);
        check("rst_c1_empty", bus_c1.y_out_empty, 1);
        check("rst_c1_dout",  bus_c1.y_out_dout,  0);
        check("rst_c1_chan",  bus_c1.y_out_chan,  0);
        check("rst_c2_busy",  bus_c2.busy,        0);
        check("rst_c2_empty", bus_c2.y_out_empty, 1);
        check("rst_c2_chan",  bus_c2.y_out_chan,  0);
        reset = 1'b1;
        @(negedge clock);

        for (int i = 0; i < 12; i++) begin
            if (vecs[i].rst != 0) do_reset();
            push(vecs[i].dut, vecs[i].din);
            pop(vecs[i].dut, ok, dat, ch);
            if (ok) begin
                check($sformatf("vec%0d_dat", i),  dat, vecs[i].exp_dat);
                check($sformatf("vec%0d_chan", i), ch,  vecs[i].exp_chan);
            end
        end

        // Decimate by 4: only samples 3 and 7 produce output.
        model_clear();
        for (int i = 0; i < 8; i++) d4_exp[i] = model_step(0, d4_in[i]);
        do_reset();
        for (int i = 0; i < 8; i++) push(2, d4_in[i]);
        pop(2, ok, dat, ch);
        if (ok) check("dec_out0", dat, d4_exp[3]);
        pop(2, ok, dat, ch);
        if (ok) check("dec_out1", dat, d4_exp[7]);
        repeat (40) @(negedge clock);
        check("dec_only_two", bus_d4.y_out_empty, 1);

        // Backpressure: no reads until the input FIFO fills, then drain while feeding the rest.
        model_clear();
        for (int i = 0; i < 40; i++) bp_exp[i] = model_step(i % 2, bp_val(i));
        do_reset();
        n_in  = 0;
        stall = 0;
        while (n_in < 40 && stall < 60) begin
            bus_c2.x_in_wr_en = 1'b0;
            if (!bus_c2.x_in_full) begin
                bus_c2.x_in_din   = bp_val(n_in);
                bus_c2.x_in_wr_en = 1'b1;
                n_in++;
                stall = 0;
            end else begin
                stall++;
            end
            @(negedge clock);
        end
        bus_c2.x_in_wr_en = 1'b0;
        check("bp_full_seen", bus_c2.x_in_full, 1);
        check("bp_accepted",  n_in,             33);
        n_out = 0;
        guard = 0;
        while (n_out < 40 && guard < 2000) begin
            bus_c2.x_in_wr_en  = 1'b0;
            bus_c2.y_out_rd_en = 1'b0;
            if (n_in < 40 && !bus_c2.x_in_full) begin
                bus_c2.x_in_din   = bp_val(n_in);
                bus_c2.x_in_wr_en = 1'b1;
                n_in++;
            end
            if (!bus_c2.y_out_empty) begin
                check($sformatf("bp_dat%0d", n_out),  $signed(bus_c2.y_out_dout), bp_exp[n_out]);
                check($sformatf("bp_chan%0d", n_out), bus_c2.y_out_chan,          n_out % 2);
                bus_c2.y_out_rd_en = 1'b1;
                n_out++;
            end
            @(negedge clock);
            guard++;
        end
        idle_inputs();
        check("bp_drained", n_out, 40);
        repeat (30) @(negedge clock);
        check("bp_no_extra", bus_c2.y_out_empty, 1);

        // Reset while the core is in the MAC phase.
        do_reset();
        push(1, 1024);
        guard = 0;
        while (!bus_c2.busy && guard < 20) begin
            @(negedge clock);
            guard++;
        end
        check("mac_busy_before", bus_c2.busy, 1);
        reset = 1'b0;
        #1;
        check("mac_rst_busy",  bus_c2.busy,        0);
        check("mac_rst_empty", bus_c2.y_out_empty, 1);
        repeat (2) @(negedge clock);
        reset = 1'b1;
        @(negedge clock);
        push(1, 1024);
        pop(1, ok, dat, ch);
        if (ok) begin
            check("mac_after_dat",  dat, 178);
            check("mac_after_chan", ch,  0);
        end

        $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
        $finish;
    end

endmodule

// File: doc/iir_mc_top.md
IIR_MC_TOP -- requirements
Module: iir_mc_top

Interface
REQ-001 SHALL have parameter CHANNELS, default 2: number of interleaved channels sharing one datapath.
REQ-002 SHALL have parameter TAPS, default 2: number of coefficients per feed-forward and feedback path.
REQ-003 SHALL have parameter DATA_SIZE, default 32: sample and coefficient width, two's complement.
REQ-004 SHALL have parameter BITS, default 10: fixed-point fraction bits removed by dequantization.
REQ-005 SHALL have parameter DECIMATION, default 1: one output written per DECIMATION samples of each channel.
REQ-006 SHALL have parameter FIFO_DEPTH, default 16: depth of the input FIFO and of the output FIFO.
REQ-007 SHALL have parameters X_COEFFS and Y_COEFFS, each TAPS x DATA_SIZE, defaults {0x000000B2, 0x000000B2} and {0x00000000, 0xFFFFFD66}.
REQ-008 SHALL have port clock, input, 1 bit: the single clock, rising-edge.
REQ-009 SHALL have port reset, input, 1 bit: asynchronous, active-low reset.
REQ-010 SHALL have ports x_in_din (input, DATA_SIZE), x_in_wr_en (input, 1) and x_in_full (output, 1): the input FIFO write side.
REQ-011 SHALL have ports y_out_dout (output, DATA_SIZE), y_out_rd_en (input, 1) and y_out_empty (output, 1): the output FIFO read side, with dout valid whenever empty is low.
REQ-012 SHALL have port y_out_chan, output, clog2(CHANNELS) bits: channel tag for y_out_dout, stored alongside the data in the output FIFO.
REQ-013 SHALL have port busy, output, 1 bit: high whenever the FSM is not in S_READ.

Function
REQ-014 SHALL treat the input stream as channel-interleaved: ch0, ch1, ..., ch(CHANNELS-1), then ch0 again; the channel counter wraps from CHANNELS-1 to 0.
REQ-015 SHALL hold TAPS-deep x and y histories per channel.
REQ-016 SHALL use FSM states S_READ, S_MAC, S_WRITE, with these transitions:
- S_READ: if the input FIFO is not empty, pop one sample, shift the current channel's x history with the new sample in slot 0, then go to S_MAC.
- S_MAC: add one tap per cycle for TAPS cycles, X_COEFFS[i]*x[i] + Y_COEFFS[i]*y[i], using the current channel's y history shifted by one with slot 0 reading as 0; then go to S_WRITE.
REQ-017 SHALL sign-extend every product into a 2*DATA_SIZE accumulator, which clears at entry to S_MAC.
REQ-018 SHALL dequantize by signed division by 2^BITS, truncating toward zero; the result is the low DATA_SIZE bits, with wrap and no saturation.
REQ-019 SHALL, in S_WRITE, commit the result to slot 0 of the channel's shifted y history on every sample, and push {channel, result} only when that channel's decimation count equals DECIMATION-1.
REQ-020 SHALL, when the output FIFO is full in S_WRITE, stall in S_WRITE with no state committed until it is not full; the commit then happens exactly once.
REQ-021 SHALL, after a commit, advance the channel counter, advance the decimation count after the last channel (wrapping to 0 after DECIMATION-1), and return to S_READ.
REQ-022 SHALL have a latency of TAPS+2 cycles from the S_READ pop to the output FIFO write when there is no backpressure; throughput is one sample per TAPS+2 cycles.
REQ-023 SHALL let x_in_full and y_out_empty reflect the FIFO flags only; writes while full and reads while empty are ignored by the FIFOs.

Reset
REQ-024 SHALL, while reset is low, asynchronously clear the FSM to S_READ, clear histories, accumulator, channel counter and decimation count to 0, and empty both FIFOs.
REQ-025 SHALL, while reset is low, hold outputs at busy=0, x_in_full=0, y_out_empty=1, y_out_dout=0 and y_out_chan=0.
REQ-026 SHALL, when reset is asserted mid-operation, discard the in-flight sample, and resume in S_READ with channel 0 after release.

Structure
REQ-027 SHALL place the coefficient array typedef, the FSM state enum and the DEQUANTIZE constant/function in package iir_mc_pkg.
REQ-028 SHALL instantiate the existing fifo module twice, with the output FIFO DATA_SIZE+clog2(CHANNELS) wide.
REQ-029 SHALL place the FSM, histories and MAC in one sub-module, iir_mc_core.

Verification
REQ-030 SHALL cover, with CHANNELS=1 and defaults: inputs 1024, 0 -> outputs 178, 62.
REQ-031 SHALL cover, with CHANNELS=1: inputs -1024, then -1 after a reset -> outputs -178, then 0 (truncation toward zero, not -1).
REQ-032 SHALL cover, with CHANNELS=2: inputs 1024, 0, 0, 0 -> outputs (178,ch0), (0,ch1), (62,ch0), (0,ch1).
REQ-033 SHALL cover, with DECIMATION=4 and CHANNELS=1: 8 samples -> exactly 2 outputs, equal to the full-rate outputs at n=3 and n=7.
REQ-034 SHALL cover holding y_out_rd_en low for 40 samples -> x_in_full asserts and no data is lost; on draining, the sequence matches the golden model with no repeats.
REQ-035 SHALL cover asserting reset in S_MAC -> busy=0 and y_out_empty=1 immediately; after release, input 1024 on ch0 -> output 178 on ch0.
